if_id_queue: RTL

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue.sv | 98 +++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular FIFO that tags each entry with
// control-transfer (cti) and branch-delay-slot (ds) flags as it is pushed.
module if_id_queue #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic                     out_cti,
  output logic                     out_delay_slot,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [DEPTH-1:0] cti_mem;
  logic [DEPTH-1:0] ds_mem;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             prev_cti;
  logic             push;
  logic             pop;
  logic             in_cti;

  // Jumps, branches, REGIMM branches, and register jumps (JR/JALR).
  function automatic logic is_cti(input logic [31:0] instr);
    logic result;
    result = 1'b0;
    case (instr[31:26])
      6'b000001, 6'b000010, 6'b000011,
      6'b000100, 6'b000101, 6'b000110, 6'b000111: result = 1'b1;
      6'b000000: result = (instr[5:0] == 6'b001000) || (instr[5:0] == 6'b001001);
      default:   result = 1'b0;
    endcase
    return result;
  endfunction

  assign in_cti    = is_cti(in_instr);
  assign in_ready  = (count < FULL_CNT) && !reset;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  assign out_instr      = out_valid ? instr_mem[rd_ptr] : 32'h0;
  assign out_pc         = out_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign out_cti        = out_valid ? cti_mem[rd_ptr]   : 1'b0;
  assign out_delay_slot = out_valid ? ds_mem[rd_ptr]    : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      prev_cti <= 1'b0;
      cti_mem  <= '0;
      ds_mem   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= 32'h0;
        pc_mem[i]    <= 32'h0;
      end
    end else if (flush) begin
      // Redirect: drop everything; any same-cycle pop already reached decode.
      count    <= '0;
      rd_ptr   <= wr_ptr;
      prev_cti <= 1'b0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= in_instr;
        pc_mem[wr_ptr]    <= in_pc;
        cti_mem[wr_ptr]   <= in_cti;
        ds_mem[wr_ptr]    <= prev_cti;
        wr_ptr            <= wr_ptr + PTR_W'(1);
        prev_cti          <= in_cti;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
